// File: rtl/da_bitserial_acc_if.sv
// Accept/result handshake bundle for the bit-serial DA accumulator.
// Upstream drives words and coefficients; downstream takes the signed dot product.
interface da_bitserial_acc_if #(
  parameter int DSIZE = 10,
  parameter int NTAP  = 5,
  parameter int CSIZE = 8,
  parameter int GSIZE = 3
);
  localparam int OSIZE = CSIZE + DSIZE + 1 + GSIZE;

  logic                       in_valid;
  logic                       in_ready;
  logic [(DSIZE+1)*NTAP-1:0]  idata;
  logic [CSIZE*NTAP-1:0]      coef;
  logic                       out_valid;
  logic                       out_ready;
  logic [OSIZE-1:0]           odata;

  modport master (
    output in_valid, idata, coef, out_ready,
    input  in_ready, out_valid, odata
  );

  modport slave (
    input  in_valid, idata, coef, out_ready,
    output in_ready, out_valid, odata
  );
endinterface

// File: rtl/da_bitserial_acc.sv
// Bit-serial distributed-arithmetic dot product, MSB first, one bit position per cycle.
// Result appears DSIZE+1 cycles after accept; a held result blocks new accepts until out_ready.
module da_bitserial_acc #(
  parameter int DSIZE = 10,
  parameter int NTAP  = 5,
  parameter int CSIZE = 8,
  parameter int GSIZE = 3
) (
  input logic              clk,
  input logic              rst_n,
  da_bitserial_acc_if.slave bus
);
  localparam int WW    = DSIZE + 1;
  localparam int OSIZE = CSIZE + DSIZE + 1 + GSIZE;
  localparam int CW    = $clog2(WW);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state, state_nxt;
  logic                     in_ready;
  logic                     accept;
  logic [WW*NTAP-1:0]       words;
  logic [CSIZE*NTAP-1:0]    coefs;
  logic [CW-1:0]            cnt;
  logic signed [OSIZE-1:0]  acc, acc_nxt, partial, odata;
  logic                     out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          in_ready  = 1'b1;
          state_nxt = bus.in_valid ? RUN : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = bus.in_valid & in_ready;

  // Words are unsigned, so every bit plane adds; no final subtraction for a sign bit.
  always_comb begin
    partial = '0;
    for (int i = 0; i < NTAP; i++) begin
      logic [WW-1:0]           word;
      logic signed [CSIZE-1:0] cf;
      word = words[i*WW +: WW];
      cf   = coefs[i*CSIZE +: CSIZE];
      if (word[cnt]) partial = partial + {{(OSIZE-CSIZE){cf[CSIZE-1]}}, cf};
    end
    acc_nxt = (acc <<< 1) + partial;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words     <= '0;
      coefs     <= '0;
      acc       <= '0;
      cnt       <= '0;
      odata     <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      words     <= bus.idata;
      coefs     <= bus.coef;
      acc       <= '0;
      cnt       <= CW'(DSIZE);
      out_valid <= 1'b0;
    end else if (state == RUN) begin
      acc <= acc_nxt;
      cnt <= cnt - 1'b1;
      if (cnt == '0) begin
        odata     <= acc_nxt;
        out_valid <= 1'b1;
      end
    end else if (state == DONE && bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.odata     = odata;
endmodule

// File: tb/tb_da_bitserial_acc.sv
// Directed bench for da_bitserial_acc: cycle-level reference model plus literal expectations.
module tb_da_bitserial_acc;
  localparam int DSIZE = 10;
  localparam int NTAP  = 5;
  localparam int CSIZE = 8;
  localparam int GSIZE = 3;
  localparam int W     = DSIZE + 1;
  localparam int OSIZE = CSIZE + DSIZE + 1 + GSIZE;

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_mis = 0;

  da_bitserial_acc_if #(.DSIZE(DSIZE), .NTAP(NTAP), .CSIZE(CSIZE), .GSIZE(GSIZE)) bus ();

  da_bitserial_acc #(.DSIZE(DSIZE), .NTAP(NTAP), .CSIZE(CSIZE), .GSIZE(GSIZE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W*NTAP-1:0] pw(input int a, b, c, d, e);
    int v[NTAP];
    logic [W*NTAP-1:0] r;
    v = '{a, b, c, d, e};
    r = '0;
    for (int i = 0; i < NTAP; i++) r[i*W +: W] = W'(v[i]);
    return r;
  endfunction

  function automatic logic [CSIZE*NTAP-1:0] pc(input int a, b, c, d, e);
    int v[NTAP];
    logic [CSIZE*NTAP-1:0] r;
    v = '{a, b, c, d, e};
    r = '0;
    for (int i = 0; i < NTAP; i++) r[i*CSIZE +: CSIZE] = CSIZE'(v[i]);
    return r;
  endfunction

  function automatic int dot(input logic [W*NTAP-1:0] d, input logic [CSIZE*NTAP-1:0] c);
    int s;
    logic signed [CSIZE-1:0] cs;
    logic [W-1:0] wd;
    s = 0;
    for (int i = 0; i < NTAP; i++) begin
      cs = c[i*CSIZE +: CSIZE];
      wd = d[i*W +: W];
      s += int'(cs) * int'(wd);
    end
    return s;
  endfunction

  // Reference model: a result is due DSIZE+1 edges after each accept and held until taken.
  bit m_busy = 0, m_valid = 0, m_acc = 0;
  int m_cnt = 0, m_odata = 0, m_pend = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_valid = 0; m_cnt = 0; m_odata = 0;
    end else begin
      m_acc = bus.in_valid && !m_busy && (!m_valid || bus.out_ready);
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 0; m_valid = 1; m_odata = m_pend;
        end
      end else if (m_valid && bus.out_ready) begin
        m_valid = 0;
      end
      if (m_acc) begin
        m_busy = 1; m_cnt = DSIZE + 1; m_pend = dot(bus.idata, bus.coef);
      end
    end
  end

  always @(negedge clk) begin
    chk("out_valid", longint'(bus.out_valid), longint'(m_valid));
    chk("in_ready", longint'(bus.in_ready), longint'(!m_busy && (!m_valid || bus.out_ready)));
    if (m_valid) chk("odata_model", longint'($signed(bus.odata)), longint'(m_odata));
  end

  task automatic send(input logic [W*NTAP-1:0] d, input logic [CSIZE*NTAP-1:0] c);
    bit ok;
    ok = 0;
    bus.in_valid = 1'b1;
    bus.idata    = d;
    bus.coef     = c;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input int exp, input bit scramble);
    int cyc;
    cyc = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.out_valid) break;
      if (scramble) begin
        bus.idata = (W*NTAP)'({$urandom(), $urandom()});
        bus.coef  = (CSIZE*NTAP)'({$urandom(), $urandom()});
      end
    end
    chk({name, "_latency"}, cyc, DSIZE + 1);
    chk(name, longint'($signed(bus.odata)), exp);
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_vec(input string name, input logic [W*NTAP-1:0] d,
                         input logic [CSIZE*NTAP-1:0] c, input int exp, input bit scramble);
    send(d, c);
    wait_result(name, exp, scramble);
    consume();
  endtask

  initial begin
    int nres;
    rst_n = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.idata = '0; bus.coef = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_odata", longint'($signed(bus.odata)), 0);
    chk("rst_in_ready", bus.in_ready, 1);

    run_vec("zero_words", pw(0, 0, 0, 0, 0), pc(127, 127, 127, 127, 127), 0, 0);
    run_vec("ones_coef", pw(1, 2, 3, 4, 5), pc(1, 1, 1, 1, 1), 15, 0);
    run_vec("alt_coef", pw(1, 2, 3, 4, 5), pc(1, -1, 1, -1, 1), 3, 0);
    run_vec("max_neg", pw(2047, 2047, 2047, 2047, 2047), pc(-128, -128, -128, -128, -128), -1310080, 0);
    run_vec("max_pos", pw(2046, 2046, 2046, 2046, 2046), pc(127, 127, 127, 127, 127), 1299210, 0);

    // Held result: a pending request must wait until the result is taken.
    send(pw(1, 2, 3, 4, 5), pc(1, 1, 1, 1, 1));
    wait_result("hold_first", 15, 0);
    bus.in_valid = 1'b1;
    bus.idata = pw(1, 2, 3, 4, 5);
    bus.coef  = pc(1, -1, 1, -1, 1);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      chk("hold_odata", longint'($signed(bus.odata)), 15);
      chk("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("hold_release_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    wait_result("hold_second", 3, 0);
    consume();

    run_vec("scrambled_inputs", pw(2047, 2047, 2047, 2047, 2047), pc(-128, -128, -128, -128, -128), -1310080, 1);

    // Abort mid-run: outputs clear without waiting for a clock edge.
    send(pw(100, 200, 300, 400, 500), pc(3, 3, 3, 3, 3));
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_odata", longint'($signed(bus.odata)), 0);
    chk("abort_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec("after_abort", pw(1, 2, 3, 4, 5), pc(1, 1, 1, 1, 1), 15, 0);

    // Back-to-back with out_ready held: one accept every DSIZE+2 cycles.
    nres = 0;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    bus.idata = pw(7, 0, 9, 1, 2047);
    bus.coef  = pc(-5, 100, 2, -128, 1);
    for (int k = 0; k < 3 * (DSIZE + 2); k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) nres++;
    end
    bus.in_valid = 1'b0;
    chk("b2b_results", nres, 3);
    @(posedge clk); #1;
    chk("b2b_drained", bus.out_valid, 0);
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
